// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus a 32-step shift-add multiplier that stalls
// upstream and emits bubbles until the product is ready.
module execute_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                validIn,
  input  logic [3:0]          aluOp,
  input  logic                aluSrc,
  input  logic [WIDTH-1:0]    operandA,
  input  logic [WIDTH-1:0]    operandB,
  input  logic [WIDTH-1:0]    immediate,
  input  logic [1:0]          writeBackControlIn,
  input  logic [1:0]          memAccessControlIn,
  input  logic [REG_BITS-1:0] rdIn,
  output logic                stall,
  output logic [1:0]          writeBackControlOut,
  output logic [1:0]          memAccessControlOut,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    writeData,
  output logic [REG_BITS-1:0] rdOut,
  output logic                zero
);

  // state | meaning
  // IDLE  | single-cycle ops; a presented MUL latches its operands here
  // RUN   | one shift-add step per edge, 32 steps, bubbles out
  // DONE  | product ready, held MUL instruction retires at this edge
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] OP_MUL = 4'd10;

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [4:0]          count_q, count_d;
  logic [1:0]          wb_q, wb_d, mem_q, mem_d;
  logic [WIDTH-1:0]    result_q, result_d, wdata_q, wdata_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                zero_q, zero_d;

  logic [WIDTH-1:0]    src_b, alu_res;
  logic [4:0]          shamt;
  logic                is_mul;

  assign src_b  = aluSrc ? immediate : operandB;
  assign shamt  = src_b[4:0];
  assign is_mul = (aluOp == OP_MUL);
  assign stall  = (state_q == S_RUN) || ((state_q == S_IDLE) && validIn && is_mul);

  always_comb begin
    alu_res = '0;
    case (aluOp)
      4'd0: alu_res = operandA + src_b;
      4'd1: alu_res = operandA - src_b;
      4'd2: alu_res = operandA & src_b;
      4'd3: alu_res = operandA | src_b;
      4'd4: alu_res = operandA ^ src_b;
      4'd5: alu_res = ~(operandA | src_b);
      4'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(src_b))};
      4'd7: alu_res = operandA << shamt;
      4'd8: alu_res = operandA >> shamt;
      4'd9: alu_res = WIDTH'($signed(operandA) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    // Bubble unless an instruction retires this edge
    wb_d     = '0;
    mem_d    = '0;
    result_d = '0;
    wdata_d  = '0;
    rd_d     = '0;
    zero_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (validIn && is_mul) begin
          mcand_d  = operandA;
          mplier_d = src_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end else if (validIn) begin
          wb_d     = writeBackControlIn;
          mem_d    = memAccessControlIn;
          result_d = alu_res;
          wdata_d  = operandB;
          rd_d     = rdIn;
          zero_d   = (alu_res == '0);
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        wb_d     = writeBackControlIn;
        mem_d    = memAccessControlIn;
        result_d = acc_q;
        wdata_d  = operandB;
        rd_d     = rdIn;
        zero_d   = (acc_q == '0);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      wb_q     <= '0;
      mem_q    <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      wb_q     <= wb_d;
      mem_q    <= mem_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      zero_q   <= zero_d;
    end
  end

  assign writeBackControlOut = wb_q;
  assign memAccessControlOut = mem_q;
  assign result              = result_q;
  assign writeData           = wdata_q;
  assign rdOut               = rd_q;
  assign zero                = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, reset corner cases and
// random instructions checked against an arithmetic reference model.
module tb_execute_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        z;
  } out_t;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [4:0]  rd;
    logic [31:0] exp_res;
  } vec_t;

  logic        clk, resetN, validIn, aluSrc, stall, zero;
  logic [3:0]  aluOp;
  logic [31:0] operandA, operandB, immediate, result, writeData;
  logic [1:0]  wbIn, memIn, wbOut, memOut;
  logic [4:0]  rdIn, rdOut;

  int n_checks = 0;
  int n_fail   = 0;

  localparam out_t BUBBLE = '{wb: 2'b0, mem: 2'b0, res: 32'h0, wd: 32'h0, rd: 5'h0, z: 1'b1};
  localparam out_t RST    = '{wb: 2'b0, mem: 2'b0, res: 32'h0, wd: 32'h0, rd: 5'h0, z: 1'b0};

  execute_stage #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk(clk), .resetN(resetN), .validIn(validIn), .aluOp(aluOp), .aluSrc(aluSrc),
    .operandA(operandA), .operandB(operandB), .immediate(immediate),
    .writeBackControlIn(wbIn), .memAccessControlIn(memIn), .rdIn(rdIn),
    .stall(stall), .writeBackControlOut(wbOut), .memAccessControlOut(memOut),
    .result(result), .writeData(writeData), .rdOut(rdOut), .zero(zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  out_t got;
  assign got = {wbOut, memOut, result, writeData, rdOut, zero};

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint unsigned prod;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return 32'($signed(a) >>> b[4:0]);
      4'd10: begin
        prod = longint'(a) * longint'(b);
        return prod[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wb=%h mem=%h res=%h wd=%h rd=%h z=%b, expected wb=%h mem=%h res=%h wd=%h rd=%h z=%b",
               name, act.wb, act.mem, act.res, act.wd, act.rd, act.z,
               exp.wb, exp.mem, exp.res, exp.wd, exp.rd, exp.z);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    validIn   = t.valid;
    aluOp     = t.op;
    aluSrc    = t.src;
    operandA  = t.a;
    operandB  = t.b;
    immediate = t.imm;
    wbIn      = t.wb;
    memIn     = t.mem;
    rdIn      = t.rd;
  endtask

  // Called just after a rising edge; leaves time just after the retiring edge.
  task automatic issue(input vec_t t, input string name);
    out_t exp;
    drive(t);
    #1;
    if (t.valid && t.op == 4'd10) begin
      for (int i = 0; i < 33; i++) begin
        check_bit({name, "_stall_hi"}, stall, 1'b1);
        @(posedge clk); #1;
        check_out({name, "_bubble"}, got, BUBBLE);
      end
    end
    check_bit({name, "_stall_lo"}, stall, 1'b0);
    @(posedge clk); #1;
    if (t.valid)
      exp = '{wb: t.wb, mem: t.mem, res: t.exp_res, wd: t.b, rd: t.rd, z: (t.exp_res == 32'h0)};
    else
      exp = BUBBLE;
    check_out(name, got, exp);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    tbl.push_back('{1'b1, 4'd0,  1'b1, 32'd5,        32'h1234,     32'hFFFFFFFF, 2'b10, 2'b00, 5'd3,  32'd4});
    tbl.push_back('{1'b1, 4'd1,  1'b0, 32'd7,        32'd7,        32'h0,        2'b01, 2'b00, 5'd4,  32'd0});
    tbl.push_back('{1'b1, 4'd6,  1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        2'b01, 2'b00, 5'd5,  32'd1});
    tbl.push_back('{1'b1, 4'd9,  1'b0, 32'h80000000, 32'd4,        32'h0,        2'b01, 2'b00, 5'd6,  32'hF8000000});
    tbl.push_back('{1'b1, 4'd5,  1'b0, 32'h0,        32'h0,        32'h0,        2'b11, 2'b00, 5'd7,  32'hFFFFFFFF});
    tbl.push_back('{1'b1, 4'd15, 1'b0, 32'd123,      32'd456,      32'h0,        2'b01, 2'b00, 5'd8,  32'h0});
    tbl.push_back('{1'b1, 4'd11, 1'b0, 32'd3,        32'd4,        32'h0,        2'b01, 2'b00, 5'd9,  32'h0});
    tbl.push_back('{1'b1, 4'd2,  1'b0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h0,        2'b01, 2'b00, 5'd10, 32'h00F0F000});
    tbl.push_back('{1'b1, 4'd3,  1'b0, 32'h12340000, 32'h00005678, 32'h0,        2'b01, 2'b00, 5'd11, 32'h12345678});
    tbl.push_back('{1'b1, 4'd4,  1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        2'b01, 2'b00, 5'd12, 32'hF0F00F0F});
    tbl.push_back('{1'b1, 4'd7,  1'b0, 32'd3,        32'h21,       32'h0,        2'b01, 2'b00, 5'd13, 32'd6});
    tbl.push_back('{1'b1, 4'd8,  1'b1, 32'h80000000, 32'hDEADBEEF, 32'd4,        2'b00, 2'b01, 5'd14, 32'h08000000});
    tbl.push_back('{1'b1, 4'd10, 1'b0, 32'd12345,    32'd678,      32'h0,        2'b00, 2'b01, 5'd15, 32'h007FB6F6});
    tbl.push_back('{1'b1, 4'd10, 1'b1, 32'h10000,    32'h5,        32'h10000,    2'b01, 2'b00, 5'd16, 32'h0});
    tbl.push_back('{1'b0, 4'd0,  1'b0, 32'hAAAA5555, 32'h1,        32'h2,        2'b11, 2'b11, 5'd31, 32'h0});
    tbl.push_back('{1'b1, 4'd0,  1'b0, 32'd10,       32'd20,       32'h0,        2'b01, 2'b00, 5'd1,  32'd30});
    tbl.push_back('{1'b1, 4'd10, 1'b1, 32'd3,        32'd7,        32'hFFFFFFFE, 2'b01, 2'b00, 5'd2,  32'hFFFFFFFA});
    tbl.push_back('{1'b1, 4'd1,  1'b0, 32'd5,        32'd9,        32'h0,        2'b01, 2'b00, 5'd3,  32'hFFFFFFFC});
    tbl.push_back('{1'b0, 4'd1,  1'b0, 32'd5,        32'd9,        32'h0,        2'b01, 2'b00, 5'd3,  32'h0});

    resetN = 1'b0;
    drive('{1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b0, 2'b0, 5'd0, 32'h0});
    #2;
    check_out("reset_outputs", got, RST);
    check_bit("reset_stall", stall, 1'b0);
    @(posedge clk); #1;
    resetN = 1'b1;

    foreach (tbl[i]) issue(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle with live outputs
    issue(tbl[0], "pre_reset_add");
    validIn = 1'b0;
    #3 resetN = 1'b0;
    #1;
    check_out("async_reset_outputs", got, RST);
    check_bit("async_reset_stall", stall, 1'b0);
    @(posedge clk); #1;
    resetN = 1'b1;

    // Reset during RUN aborts the multiply; held MUL restarts from scratch
    drive(tbl[12]);
    repeat (10) @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    check_out("mul_abort_outputs", got, RST);
    check_bit("mul_abort_stall", stall, 1'b1);
    @(posedge clk); #1;
    check_out("mul_abort_held", got, RST);
    resetN = 1'b1;
    issue(tbl[12], "mul_restart");

    for (int i = 0; i < 60; i++) begin
      v.valid = ($urandom_range(0, 7) != 0);
      v.op    = (i % 12 == 5) ? 4'd10 : 4'($urandom_range(0, 15));
      v.src   = 1'($urandom_range(0, 1));
      v.a     = $urandom;
      v.b     = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      v.imm   = (i % 4 == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      v.wb    = 2'($urandom_range(0, 3));
      v.mem   = 2'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 31));
      v.exp_res = ref_alu(v.op, v.a, v.src ? v.imm : v.b);
      issue(v, $sformatf("rand%0d_op%0d", i, v.op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline execute stage: takes decoded operands and control from the decode stage. It computes an ALU result, including a multi-cycle iterative multiply, and registers the result plus the pass-through control, store data and destination register into the memory-access stage directly downstream. During a multiply it stalls the upstream stages and sends bubbles (all control zero) downstream, so the memory stage never writes memory or the register file because of a stalled slot.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- REG_BITS, 5, destination register index width.

- clk  in  1  clock; all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- validIn  in  1  decode slot holds a real instruction.
- aluOp  in  4  operation select (encoding below).
- aluSrc  in  1  1: operand B = immediate; 0: operand B = operandB.
- operandA  in  32  rs value.
- operandB  in  32  rt value.
- immediate  in  32  already sign-extended immediate.
- writeBackControlIn  in  2  write-back control, passed through.
- memAccessControlIn  in  2  {memRead, memWrite}, passed through.
- rdIn  in  5  destination register, passed through.
- stall  out  1  upstream must hold all inputs stable while high.
- writeBackControlOut  out  2  registered.
- memAccessControlOut  out  2  registered.
- result  out  32  registered ALU result; also the memory address for the next stage.
- writeData  out  32  registered operandB (store data), independent of aluSrc.
- rdOut  out  5  registered.
- zero  out  1  registered, result == 0.

## Operation
- srcB = aluSrc ? immediate : operandB.
- aluOp encoding:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SLT: signed A < srcB gives 1, else 0.
  - 7 SLL, 8 SRL, 9 SRA: shift amount srcB[4:0].
  - 10 MUL: low 32 bits of A*srcB.
  - 11–15: result 0.
- All arithmetic wraps modulo 2^32; there are no overflow flags.
- Non-MUL op with validIn=1: single cycle. At the edge, all outputs load the computed values and pass-through fields.
- validIn=0 (any state other than DONE): bubble is loaded. Bubble means writeBackControlOut=0, memAccessControlOut=0, result=0, writeData=0, rdOut=0, zero=1.
- MUL state machine:
  - States: IDLE, RUN, DONE.
  - IDLE with validIn=1 and aluOp=10: stall=1 in that cycle. At the edge, latch mcand=A, mplier=srcB, acc=0, count=0, and go to RUN. A bubble is emitted.
  - RUN: stall=1. Each edge does one radix-2 shift-add step:
    - if mplier[0] then acc += mcand;
    - mcand <<= 1; mplier >>= 1; count++.
    - A bubble is emitted at each edge.
    - At the edge where count==31 (32nd step), go to DONE.
  - DONE: stall=0. The held MUL instruction is consumed at this edge: result=acc, zero=(acc==0), and control/rd/writeData come from the held inputs. Next state is IDLE; the MUL does not restart.
- stall = (state==RUN) | (state==IDLE & validIn & aluOp==10). This is combinational from the inputs in IDLE.
- No early termination: every MUL takes the full count, whatever the operand values.

## Timing
- Non-MUL latency: 1 edge. Inputs presented in cycle n appear on the outputs after edge n. Throughput is 1 per cycle.
- MUL latency: stall is high for exactly 33 consecutive cycles (1 IDLE + 32 RUN). The result appears after the edge that ends the 34th cycle (DONE). 33 bubbles precede it.
- The memory stage samples the outputs on the following falling edge; outputs must be stable from each rising edge.
- Reset (resetN=0, asynchronous, any time):
  - all outputs 0, except zero=0;
  - state=IDLE; acc, count, mcand and mplier = 0.
  - stall follows its combinational definition, so stall is 0 unless a MUL is presented.
- Reset during RUN aborts the multiply, with no partial result emitted. After release, a still-presented MUL restarts from IDLE with a full 33-cycle stall.
- Inputs that change while stall=1 are a protocol violation; behaviour is undefined.

## Test plan
- Reset: assert resetN low mid-cycle with non-zero outputs → all outputs 0 immediately, before the next edge; stall=0 with validIn=0.
- ADD immediate: A=5, immediate=0xFFFFFFFF, aluSrc=1, writeBackControlIn=2'b10, memAccessControlIn=2'b00, rdIn=3 → after one edge: result=4, zero=0, rdOut=3, controls passed through, writeData=operandB.
- ALU sweep:
  - SUB 7-7 → result 0, zero=1;
  - SLT A=0xFFFFFFFF, B=1 → 1;
  - SRA 0x80000000 by 4 → 0xF8000000;
  - NOR 0,0 → 0xFFFFFFFF;
  - aluOp=15 → 0.
- MUL 12345*678: stall high exactly 33 cycles, each with bubble outputs (memAccessControlOut=0) → then result=0x007FB6F6, controls/rd passed. Also 0x10000*0x10000 → result 0, zero=1.
- Reset mid-MUL: pulse resetN low during RUN cycle 10 with the MUL held → outputs 0, no result emitted; after release, a full 33-cycle stall then the correct product.
- Back-to-back: ADD, MUL, SUB with validIn=1, then validIn=0 → ADD result, 33 bubbles, MUL result, SUB result, bubble. The SUB is not lost or duplicated.
